input_payload_sampler: RTL and testbench
========================================

# input_payload_sampler

Conditions the seven raw operator inputs (joystick VRx/VRy, joystick switch SW, buttons btn1..btn4) and turns them into one-byte LoRa payloads for the register-write sequencer. Each input is synchronised and debounced, and the block packs them with a sequence bit. The payload is offered over a valid/ready handshake whenever the debounced state changes or a heartbeat interval expires. The block sits directly upstream of the sequencer's FIFO-write step and runs on the same 10 MHz clock.

## Interface
- DEBOUNCE_CYCLES, 100_000: cycles an input must hold a new level before it is accepted (10 ms at 10 MHz); legal range ≥ 2.
- HEARTBEAT_CYCLES, 10_000_000: maximum cycles between handshakes with no input change (1 s); legal range ≥ 4.
- clk  in  1  10 MHz system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- raw_in  in  7  asynchronous inputs, [6]=VRx [5]=VRy [4]=SW [3]=btn1 [2]=btn2 [1]=btn3 [0]=btn4.
- payload  out  8  {stable[6:0], seq}; held constant while payload_valid=1.
- payload_valid  out  1  payload offered to the sequencer.
- payload_ready  in  1  sequencer consumes payload this cycle.
- stable  out  7  current debounced input levels, for debug and LEDs.

## Operation
- Synchroniser: 2-FF per bit, reset to 0.
- Debounce, per bit:
  - The counter clears whenever the synced bit equals stable.
  - While they differ, the counter increments.
  - On the cycle the counter equals DEBOUNCE_CYCLES-1, stable takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches stable.
- last_sent[6:0] holds the stable vector of the most recent handshake. seq is a 1-bit toggle.
- Heartbeat counter:
  - Increments every cycle and saturates at HEARTBEAT_CYCLES-1; hb_due = (counter == HEARTBEAT_CYCLES-1).
  - Clears on every handshake.
- FSM, two states:
  - IDLE: if (stable != last_sent) or hb_due, load payload <= {stable, seq}, set payload_valid, go to OFFER. Otherwise stay.
  - OFFER: payload and payload_valid are held. On payload_valid && payload_ready: last_sent <= payload[7:1], seq <= ~seq, heartbeat clears, payload_valid drops the next cycle, go to IDLE.
- A change and hb_due in the same IDLE cycle produce one payload, not two.
- Inputs that change during OFFER do not alter the held payload. The change is detected in the first IDLE cycle after the handshake, so a back-to-back payload follows with at most 1 idle cycle.
- payload_ready while in IDLE is ignored.
- Reset mid-OFFER: the offer is abandoned. payload_valid drops asynchronously and all state returns to reset values.

## Timing
- Reset values: payload=8'h00, payload_valid=0, stable=7'h00, seq=0, last_sent=7'h00, every counter 0, FSM=IDLE.
- There is no payload right after reset unless an input is held high long enough to debounce, or the heartbeat expires.
- Latency, raw_in change to stable update: 2 sync cycles + DEBOUNCE_CYCLES cycles.
- Latency, stable change to payload_valid high: 1 cycle.
- Handshake: transfer on the rising edge where both signals are high. payload_valid may rise regardless of payload_ready, and it never drops without a transfer (except reset). Ready held high gives 1 payload per 2 cycles at most.
- Heartbeat: with inputs static and ready held high, payload_valid rises HEARTBEAT_CYCLES cycles after the previous handshake edge.
- All outputs are registered. There is no combinational path from payload_ready to any output.

## Structure
- The shared package `sx1278_pkg` holds:
  - raw_in bit-index constants (VRX_BIT..BTN4_BIT);
  - the IDLE/OFFER state encoding;
  - PAYLOAD_W=8 and FIFO/RegPayloadLength values reused by the sequencer.
- Sub-module `debounce_bit` (synchroniser + counter + stable flop, parameter DEBOUNCE_CYCLES) is instantiated 7 times via generate. The FSM, heartbeat, seq and last_sent stay in the top.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, HEARTBEAT_CYCLES=64.
- Reset, raw_in=0, ready=1 -> first payload=8'h00 valid 64 cycles after reset release; next is 8'h01 64 cycles after that handshake.
- raw_in 7'h00→7'h41 (VRx, btn4) held, ready=1 -> stable=7'h41 after 6 cycles; payload=8'h82 one cycle later; one handshake only.
- btn2 pulses high for 3 cycles -> stable unchanged; no payload before heartbeat.
- Change applied with ready=0 -> payload stays 8'h82-style constant for 20 cycles. A further change during OFFER is delivered as the next payload with seq toggled, 1 idle cycle after the handshake.
- Change and heartbeat expiry in the same IDLE cycle -> exactly one payload; seq advances by 1.
- rst_n low during OFFER -> payload_valid=0, payload=0 immediately (asynchronous); after release, behaviour matches the first scenario.

Source files
------------

// File: rtl/sx1278_pkg.sv
// Shared constants for the SX1278 LoRa link.
// Input bit map, sampler FSM encoding, FIFO values.
package sx1278_pkg;

  localparam int RAW_W     = 7;
  localparam int PAYLOAD_W = 8;

  localparam int VRX_BIT  = 6;
  localparam int VRY_BIT  = 5;
  localparam int SW_BIT   = 4;
  localparam int BTN1_BIT = 3;
  localparam int BTN2_BIT = 2;
  localparam int BTN3_BIT = 1;
  localparam int BTN4_BIT = 0;

  localparam logic [7:0] REG_FIFO           = 8'h00;
  localparam logic [7:0] REG_FIFO_ADDR_PTR  = 8'h0D;
  localparam logic [7:0] REG_FIFO_TX_BASE   = 8'h0E;
  localparam logic [7:0] REG_PAYLOAD_LENGTH = 8'h22;
  localparam logic [7:0] FIFO_TX_BASE       = 8'h80;
  localparam logic [7:0] PAYLOAD_LENGTH     = 8'd1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } smp_state_e;

  function automatic logic [PAYLOAD_W-1:0] pack_payload(
    input logic [RAW_W-1:0] lvl,
    input logic             seq
  );
    return {lvl, seq};
  endfunction

endpackage

// File: rtl/input_payload_sampler_debounce_bit.sv
// One input channel: 2-FF synchroniser then
// a hold-time debouncer feeding the stable level.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // Two-stage synchroniser for the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  // Accept a new level only after it has held for the full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      stable <= 1'b0;
    end else if (sync_q[1] == stable) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q  <= '0;
      stable <= sync_q[1];
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/input_payload_sampler.sv
// Debounces the operator inputs and offers one-byte
// payloads on change or heartbeat via valid/ready.
module input_payload_sampler
  import sx1278_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 100_000,
  parameter int HEARTBEAT_CYCLES = 10_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [RAW_W-1:0]     raw_in,
  output logic [PAYLOAD_W-1:0] payload,
  output logic                 payload_valid,
  input  logic                 payload_ready,
  output logic [RAW_W-1:0]     stable
);

  localparam int HW = $clog2(HEARTBEAT_CYCLES);
  localparam logic [HW-1:0] HB_MAX =
    HW'(HEARTBEAT_CYCLES - 1);

  smp_state_e           state_q;
  smp_state_e           state_d;
  logic [RAW_W-1:0]     last_sent_q;
  logic                 seq_q;
  logic [HW-1:0]        hb_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic                 hb_due;
  logic                 send_req;
  logic                 load;
  logic                 xfer;

  for (genvar i = 0; i < RAW_W; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_in[i]),
      .stable(stable[i])
    );
  end

  assign hb_due   = (hb_q == HB_MAX);
  assign send_req = (stable != last_sent_q) || hb_due;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: offer on change or heartbeat, return on transfer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (send_req)      state_d = ST_OFFER;
      ST_OFFER: if (payload_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM strobes: payload load in IDLE, transfer in OFFER.
  always_comb begin
    load = 1'b0;
    xfer = 1'b0;
    unique case (state_q)
      ST_IDLE:  load = send_req;
      ST_OFFER: xfer = payload_ready;
      default: ;
    endcase
  end

  // Payload is captured once and held through the offer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      payload_q <= '0;
    end else if (load) begin
      payload_q <= pack_payload(stable, seq_q);
    end
  end

  // Handshake bookkeeping: remember what was sent, flip seq.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_sent_q <= '0;
      seq_q       <= 1'b0;
    end else if (xfer) begin
      last_sent_q <= payload_q[PAYLOAD_W-1:1];
      seq_q       <= ~seq_q;
    end
  end

  // Heartbeat: saturating count since the last handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_q <= '0;
    end else if (xfer) begin
      hb_q <= '0;
    end else if (!hb_due) begin
      hb_q <= hb_q + 1'b1;
    end
  end

  assign payload       = payload_q;
  assign payload_valid = (state_q == ST_OFFER);

endmodule

// File: tb/tb_input_payload_sampler.sv
// Bench for input_payload_sampler: scoreboard of
// expected payloads plus table-driven input patterns.
module tb_input_payload_sampler;

  localparam int DB = 4;
  localparam int HB = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] raw_in = 7'h00;
  logic [7:0] payload;
  logic       payload_valid;
  logic       payload_ready = 1'b1;
  logic [6:0] stable;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  logic [7:0] sb[$];
  logic       exp_seq = 1'b0;
  logic       hold_armed = 1'b0;
  logic [7:0] hold_val = 8'h00;

  typedef struct {
    logic [6:0] raw;
    int         pulse;
    logic [6:0] exp_stable;
  } vec_t;

  vec_t vecs[6];

  input_payload_sampler #(
    .DEBOUNCE_CYCLES (DB),
    .HEARTBEAT_CYCLES(HB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .raw_in       (raw_in),
    .payload      (payload),
    .payload_valid(payload_valid),
    .payload_ready(payload_ready),
    .stable       (stable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input logic [6:0] lvl);
    sb.push_back({lvl, exp_seq});
    exp_seq = ~exp_seq;
  endtask

  task automatic wait_valid(input string name,
                            input int exp_n);
    int n;
    n = 0;
    while (!payload_valid && n < 300) begin
      tick();
      n++;
    end
    chk(name, n, exp_n);
  endtask

  // Monitor: transfers pop the scoreboard; held payload must not move.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_armed <= 1'b0;
    end else begin
      if (hold_armed && payload_valid)
        chk("hold", payload, hold_val);
      if (payload_valid && payload_ready) begin
        xfers++;
        if (sb.size() == 0) begin
          chk("unexpected_payload", payload, 8'hxx);
        end else begin
          chk("payload", payload, sb.pop_front());
        end
      end
      hold_armed <= payload_valid && !payload_ready;
      hold_val   <= payload;
    end
  end

  initial begin
    logic [6:0] held;
    logic [7:0] p41;
    logic [7:0] p03;
    logic [7:0] p60;
    int x0;

    vecs[0] = '{raw: 7'h45, pulse: 3, exp_stable: 7'h41};
    vecs[1] = '{raw: 7'h7F, pulse: 0, exp_stable: 7'h7F};
    vecs[2] = '{raw: 7'h00, pulse: 0, exp_stable: 7'h00};
    vecs[3] = '{raw: 7'h10, pulse: 2, exp_stable: 7'h00};
    vecs[4] = '{raw: 7'h2A, pulse: 0, exp_stable: 7'h2A};
    vecs[5] = '{raw: 7'h55, pulse: 0, exp_stable: 7'h55};

    // Reset state
    ticks(3);
    chk("rst_valid", payload_valid, 1'b0);
    chk("rst_payload", payload, 8'h00);
    chk("rst_stable", stable, 7'h00);

    // Heartbeat payloads after reset
    push(7'h00);
    push(7'h00);
    rst_n = 1'b1;
    wait_valid("hb_first_lat", HB);
    tick();
    chk("hb_drop", payload_valid, 1'b0);
    wait_valid("hb_second_lat", HB);
    tick();

    // VRx + btn4 change
    x0 = xfers;
    push(7'h41);
    raw_in = 7'h41;
    ticks(5);
    chk("db_early", stable, 7'h00);
    tick();
    chk("db_stable", stable, 7'h41);
    tick();
    chk("chg_valid", payload_valid, 1'b1);
    chk("chg_payload", payload, 8'h82);
    ticks(21);
    chk("chg_once", xfers - x0, 1);
    held = 7'h41;

    // Table of held patterns and glitches
    foreach (vecs[i]) begin
      x0 = xfers;
      if (vecs[i].exp_stable != held)
        push(vecs[i].exp_stable);
      raw_in = vecs[i].raw;
      if (vecs[i].pulse > 0) begin
        ticks(vecs[i].pulse);
        raw_in = held;
      end
      ticks(10);
      chk($sformatf("vec%0d_stable", i),
          stable, vecs[i].exp_stable);
      chk($sformatf("vec%0d_xfers", i), xfers - x0,
          (vecs[i].exp_stable != held) ? 1 : 0);
      held = vecs[i].exp_stable;
    end

    // Backpressure and change during offer
    payload_ready = 1'b0;
    p41 = {7'h41, exp_seq};
    push(7'h41);
    raw_in = 7'h41;
    ticks(7);
    chk("bp_valid", payload_valid, 1'b1);
    ticks(20);
    chk("bp_valid_held", payload_valid, 1'b1);
    chk("bp_payload", payload, p41);
    p03 = {7'h03, exp_seq};
    push(7'h03);
    raw_in = 7'h03;
    ticks(10);
    chk("bp_stable", stable, 7'h03);
    chk("bp_payload2", payload, p41);
    payload_ready = 1'b1;
    tick();
    chk("b2b_idle", payload_valid, 1'b0);
    tick();
    chk("b2b_valid", payload_valid, 1'b1);
    chk("b2b_payload", payload, p03);
    tick();

    // Change and heartbeat expiry coincide
    x0 = xfers;
    ticks(HB - 7);
    p60 = {7'h60, exp_seq};
    push(7'h60);
    raw_in = 7'h60;
    ticks(DB + 2);
    chk("co_stable", stable, 7'h60);
    tick();
    chk("co_valid", payload_valid, 1'b1);
    chk("co_payload", payload, p60);
    ticks(21);
    chk("co_once", xfers - x0, 1);

    // Reset during an offer
    payload_ready = 1'b0;
    push(7'h0F);
    raw_in = 7'h0F;
    ticks(7);
    chk("ro_valid", payload_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("ro_valid_drop", payload_valid, 1'b0);
    chk("ro_payload", payload, 8'h00);
    chk("ro_stable", stable, 7'h00);
    raw_in = 7'h00;
    sb.delete();
    exp_seq = 1'b0;
    ticks(3);
    push(7'h00);
    push(7'h00);
    rst_n = 1'b1;
    payload_ready = 1'b1;
    wait_valid("ro_hb_first_lat", HB);
    tick();
    wait_valid("ro_hb_second_lat", HB);
    tick();
    ticks(2);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
